// File: rtl/conv_pkg.sv
// conv_pkg: constants and FSM encoding shared by the conv-unit feeder and the
// convolution unit itself.
//   IN_WIDTH    sample width of IFM and weight values
//   IMG_DIM     IFM tile edge, K_DIM kernel edge
//   IFM_CNT     samples per tile, W_CNT weights per kernel
//   OFM_CNT     results the conv unit returns per tile
//   WADDR_BASE  first tile-buffer address holding a weight
//   BUF_DEPTH   tile-buffer entries (IFM followed by weights)
package conv_pkg;

   localparam int IN_WIDTH   = 16;
   localparam int IMG_DIM    = 14;
   localparam int K_DIM      = 3;
   localparam int IFM_CNT    = IMG_DIM * IMG_DIM;
   localparam int W_CNT      = K_DIM * K_DIM;
   localparam int OFM_CNT    = (IMG_DIM - K_DIM + 1) * (IMG_DIM - K_DIM + 1);
   localparam int WADDR_BASE = IFM_CNT;
   localparam int BUF_DEPTH  = IFM_CNT + W_CNT;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/conv_stream_feeder_if.sv
// conv_stream_feeder_if: host write/control bus plus the conv-unit stream.
//   host side : wr_en, wr_addr, wr_data, start -> feeder; busy, done, res_cnt,
//               err_extra <- feeder
//   conv side : in_valid, In_IFM, In_Weight -> conv unit; out_valid <- conv unit
// Stream semantics: there is no ready. Every cycle with in_valid=1 transfers one
// In_IFM/In_Weight pair and the conv unit must take it; every cycle with
// out_valid=1 reports exactly one result, which the feeder always accepts.
// modport master is the feeder's view, slave is the host/conv-unit view.
interface conv_stream_feeder_if;
   import conv_pkg::*;

   logic                wr_en;
   logic [7:0]          wr_addr;
   logic [IN_WIDTH-1:0] wr_data;
   logic                start;
   logic                busy;
   logic                done;
   logic [7:0]          res_cnt;
   logic                err_extra;
   logic                in_valid;
   logic [IN_WIDTH-1:0] In_IFM;
   logic [IN_WIDTH-1:0] In_Weight;
   logic                out_valid;

   modport master (
      input  wr_en, wr_addr, wr_data, start, out_valid,
      output busy, done, res_cnt, err_extra, in_valid, In_IFM, In_Weight
   );

   modport slave (
      output wr_en, wr_addr, wr_data, start, out_valid,
      input  busy, done, res_cnt, err_extra, in_valid, In_IFM, In_Weight
   );

endinterface

// File: rtl/conv_tile_buf.sv
// conv_tile_buf: BUF_DEPTH x IN_WIDTH register file holding one IFM tile
// (addresses 0..IFM_CNT-1) and one kernel (WADDR_BASE..BUF_DEPTH-1).
//   clk      write clock
//   we       write strobe; out-of-range addresses are ignored
//   waddr    write address, wdata write data
//   ifm_idx  IFM read index  -> ifm_data (combinational, 0 when out of range)
//   w_idx    weight index    -> w_data   (combinational, 0 when out of range)
// Contents are deliberately not reset so a tile survives a run abort.
module conv_tile_buf
   import conv_pkg::*;
(
   input  logic                clk,
   input  logic                we,
   input  logic [7:0]          waddr,
   input  logic [IN_WIDTH-1:0] wdata,
   input  logic [7:0]          ifm_idx,
   input  logic [3:0]          w_idx,
   output logic [IN_WIDTH-1:0] ifm_data,
   output logic [IN_WIDTH-1:0] w_data
);

   logic [IN_WIDTH-1:0] mem [BUF_DEPTH];
   logic [7:0]          w_addr;

   always_ff @(posedge clk) begin
      if (we && (waddr < 8'(BUF_DEPTH))) begin
         mem[waddr] <= wdata;
      end
   end

   assign w_addr   = 8'(WADDR_BASE) + {4'd0, w_idx};
   assign ifm_data = (ifm_idx < 8'(IFM_CNT)) ? mem[ifm_idx] : '0;
   assign w_data   = (w_idx < 4'(W_CNT)) ? mem[w_addr] : '0;

endmodule

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: streams a preloaded IFM tile and kernel to the conv unit
// and counts the results it returns.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         conv_stream_feeder_if.master (host bus + conv-unit stream)
//   state_dbg   current FSM state
// On an accepted start the tile is sent as IFM_CNT back-to-back in_valid
// cycles (weights ride along on the first W_CNT cycles), then the block waits
// in DRAIN until OFM_CNT out_valid pulses have been counted and pulses done.
module conv_stream_feeder
   import conv_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   conv_stream_feeder_if.master bus,
   output fsm_state_t           state_dbg
);

   fsm_state_t          state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          res_cnt_q, res_cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                in_valid_q, in_valid_d;
   logic [IN_WIDTH-1:0] ifm_q, ifm_d;
   logic [IN_WIDTH-1:0] w_q, w_d;
   logic                err_q, err_d;
   logic [IN_WIDTH-1:0] ifm_rd, w_rd;
   logic                buf_we, start_ok, res_inc;

   // Writes are locked out during a run; a start in the same cycle wins.
   assign buf_we = bus.wr_en && !busy_q && !bus.start;

   conv_tile_buf u_buf (
      .clk      (clk),
      .we       (buf_we),
      .waddr    (bus.wr_addr),
      .wdata    (bus.wr_data),
      .ifm_idx  (cnt_q),
      .w_idx    (cnt_q[3:0]),
      .ifm_data (ifm_rd),
      .w_data   (w_rd)
   );

   // done_q is only ever high in IDLE; a start in that cycle is ignored.
   assign start_ok = bus.start && (state_q == IDLE) && !done_q;
   assign res_inc  = bus.out_valid && (state_q != IDLE) && (res_cnt_q < 8'(OFM_CNT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      res_cnt_d  = res_cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      in_valid_d = in_valid_q;
      ifm_d      = ifm_q;
      w_d        = w_q;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            // cnt_q rests at 0 in IDLE, so the buffer already presents entry 0.
            if (start_ok) begin
               state_d    = STREAM;
               busy_d     = 1'b1;
               in_valid_d = 1'b1;
               ifm_d      = ifm_rd;
               w_d        = w_rd;
               cnt_d      = 8'd1;
               res_cnt_d  = '0;
               err_d      = 1'b0;
            end
         end
         STREAM: begin
            if (cnt_q < 8'(IFM_CNT)) begin
               ifm_d = ifm_rd;
               w_d   = (cnt_q < 8'(W_CNT)) ? w_rd : '0;
               cnt_d = cnt_q + 8'd1;
            end else begin
               in_valid_d = 1'b0;
               ifm_d      = '0;
               w_d        = '0;
               cnt_d      = '0;
               state_d    = DRAIN;
            end
         end
         default: begin
         end
      endcase

      // Results are counted in STREAM and DRAIN; anything else is surplus.
      if (res_inc) begin
         res_cnt_d = res_cnt_q + 8'd1;
      end else if (bus.out_valid) begin
         err_d = 1'b1;
      end

      if ((state_q == DRAIN) && (res_cnt_d == 8'(OFM_CNT))) begin
         done_d  = 1'b1;
         busy_d  = 1'b0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         res_cnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         in_valid_q <= 1'b0;
         ifm_q      <= '0;
         w_q        <= '0;
         err_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         res_cnt_q  <= res_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         in_valid_q <= in_valid_d;
         ifm_q      <= ifm_d;
         w_q        <= w_d;
         err_q      <= err_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.res_cnt   = res_cnt_q;
   assign bus.err_extra = err_q;
   assign bus.in_valid  = in_valid_q;
   assign bus.In_IFM    = ifm_q;
   assign bus.In_Weight = w_q;
   assign state_dbg     = state_q;

endmodule
